// File: rtl/ppc_pkg.sv
// ppc_pkg: shared definitions for the ping-pong counter run controller.
//   - state_t  : controller state encoding (2 bits; code 3 unused, treated as IDLE)
//   - CNT_W_DEF: default bound / counter width
//   - MAX_RST / MIN_RST: bound register values after reset
package ppc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 4;

    localparam logic [CNT_W_DEF-1:0] MAX_RST = 4'hF;
    localparam logic [CNT_W_DEF-1:0] MIN_RST = 4'h0;

endpackage

// File: rtl/ppc_prescaler.sv
// ppc_prescaler: divides the clock into a one-cycle terminal-count strobe.
//   i_clk  : system clock, rising edge
//   i_rst  : asynchronous active-high reset (count -> 0)
//   i_clr  : synchronous clear (count -> 0), dominates i_run
//   i_run  : count advances 0..TICK_DIV-1 and wraps while high, holds while low
//   o_tc   : high when count == TICK_DIV-1 and i_run
module ppc_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    output logic o_tc
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] TC_VAL = W'(TICK_DIV - 1);

    logic [W-1:0] r_cnt;
    logic         w_at_tc;

    assign w_at_tc = (r_cnt == TC_VAL);
    assign o_tc    = i_run && w_at_tc;

    // Prescale counter: clear, wrap at terminal count, or hold when not running.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= W'(0);
        end else if (i_clr) begin
            r_cnt <= W'(0);
        end else if (i_run) begin
            if (w_at_tc) begin
                r_cnt <= W'(0);
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/ping_pong_ctrl.sv
// ping_pong_ctrl: run controller for the ping-pong counter.
// Latches max/min bounds in IDLE, holds the counter in reset while idle,
// paces it with a divided enable strobe, and aligns flip requests to a step.
//   i_clk, i_rst       : clock, asynchronous active-high reset
//   i_sw_val           : switch value for bound loads
//   i_load_max/min     : one-cycle load pulses (honoured in IDLE only)
//   i_start / i_stop   : run/resume, pause/abort (stop wins when both pulse)
//   i_flip_req         : direction flip request pulse
//   o_cnt_rst_n        : counter synchronous reset, active-low (low in IDLE)
//   o_cnt_enable       : counter step strobe
//   o_cnt_flip         : counter flip, only ever high with o_cnt_enable
//   o_cnt_max/min      : latched bounds
//   o_state            : current state code
//   o_cfg_err          : sticky, start refused because max <= min
module ping_pong_ctrl
    import ppc_pkg::*;
#(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [CNT_W-1:0] i_sw_val,
    input  logic             i_load_max,
    input  logic             i_load_min,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_flip_req,
    output logic             o_cnt_rst_n,
    output logic             o_cnt_enable,
    output logic             o_cnt_flip,
    output logic [CNT_W-1:0] o_cnt_max,
    output logic [CNT_W-1:0] o_cnt_min,
    output logic [1:0]       o_state,
    output logic             o_cfg_err
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] w_max_next;
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] w_min_next;
    logic             r_flip_pend;
    logic             w_flip_pend_next;
    logic             r_cfg_err;
    logic             w_cfg_err_next;
    logic             w_presc_clr;
    logic             w_run;
    logic             w_tc;
    logic             w_flip;

    // The prescaler only advances in RUN, so PAUSE freezes it mid-period.
    assign w_run = (r_state == ST_RUN);

    ppc_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_presc (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (w_presc_clr),
        .i_run (w_run),
        .o_tc  (w_tc)
    );

    // flip_req feeds the flip directly so a request in the terminal cycle is not delayed.
    assign w_flip       = w_tc && (r_flip_pend || i_flip_req);
    assign o_cnt_enable = w_tc;
    assign o_cnt_flip   = w_flip;
    assign o_cnt_rst_n  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign o_cnt_max    = r_max;
    assign o_cnt_min    = r_min;
    assign o_state      = r_state;
    assign o_cfg_err    = r_cfg_err;

    // State, bound, pending-flip and error registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_max       <= CNT_W'(MAX_RST);
            r_min       <= CNT_W'(MIN_RST);
            r_flip_pend <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_max       <= w_max_next;
            r_min       <= w_min_next;
            r_flip_pend <= w_flip_pend_next;
            r_cfg_err   <= w_cfg_err_next;
        end
    end

    // Next-state and next-register decode; stop has priority over start everywhere.
    always_comb begin
        w_state_next     = r_state;
        w_max_next       = r_max;
        w_min_next       = r_min;
        w_flip_pend_next = r_flip_pend;
        w_cfg_err_next   = r_cfg_err;
        w_presc_clr      = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (i_stop) begin
                    w_state_next = ST_PAUSE;
                end else begin
                    w_state_next = ST_RUN;
                end
                // A flip consumes the pending request and any same-cycle request.
                if (w_flip) begin
                    w_flip_pend_next = 1'b0;
                end else if (i_flip_req) begin
                    w_flip_pend_next = 1'b1;
                end else begin
                    w_flip_pend_next = r_flip_pend;
                end
            end

            ST_PAUSE: begin
                if (i_stop) begin
                    w_state_next     = ST_IDLE;
                    w_presc_clr      = 1'b1;
                    w_flip_pend_next = 1'b0;
                end else begin
                    if (i_start) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_PAUSE;
                    end
                    if (i_flip_req) begin
                        w_flip_pend_next = 1'b1;
                    end else begin
                        w_flip_pend_next = r_flip_pend;
                    end
                end
            end

            // IDLE, and the unused code 3 which behaves as IDLE.
            default: begin
                w_presc_clr      = 1'b1;
                w_flip_pend_next = 1'b0;
                w_state_next     = ST_IDLE;
                if (i_load_max) begin
                    w_max_next = i_sw_val;
                end else begin
                    w_max_next = r_max;
                end
                if (i_load_min) begin
                    w_min_next = i_sw_val;
                end else begin
                    w_min_next = r_min;
                end
                if (i_start && !i_stop) begin
                    if (r_max > r_min) begin
                        w_state_next   = ST_RUN;
                        w_cfg_err_next = 1'b0;
                    end else begin
                        w_cfg_err_next = 1'b1;
                    end
                end else if (i_load_max || i_load_min) begin
                    w_cfg_err_next = 1'b0;
                end else begin
                    w_cfg_err_next = r_cfg_err;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Directed bench for ping_pong_ctrl (TICK_DIV=4, CNT_W=4).
module tb_ping_pong_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_val = 4'h0;
    logic       load_max = 1'b0;
    logic       load_min = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       flip_req = 1'b0;
    logic       cnt_rst_n;
    logic       cnt_enable;
    logic       cnt_flip;
    logic [3:0] cnt_max;
    logic [3:0] cnt_min;
    logic [1:0] state;
    logic       cfg_err;

    int n_chk  = 0;
    int n_fail = 0;

    ping_pong_ctrl #(.TICK_DIV(4), .CNT_W(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_sw_val     (sw_val),
        .i_load_max   (load_max),
        .i_load_min   (load_min),
        .i_start      (start),
        .i_stop       (stop),
        .i_flip_req   (flip_req),
        .o_cnt_rst_n  (cnt_rst_n),
        .o_cnt_enable (cnt_enable),
        .o_cnt_flip   (cnt_flip),
        .o_cnt_max    (cnt_max),
        .o_cnt_min    (cnt_min),
        .o_state      (state),
        .o_cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; return just after the falling edge, away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---- reset then idle ----
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
        check("rst_max", 32'(cnt_max), 32'd15);
        check("rst_min", 32'(cnt_min), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_no_enable", 32'(cnt_enable), 32'd0);
        end

        // ---- config and run ----
        sw_val = 4'd9; load_max = 1'b1;
        tick();
        load_max = 1'b0; sw_val = 4'd3; load_min = 1'b1;
        tick();
        load_min = 1'b0;
        check("cfg_max", 32'(cnt_max), 32'd9);
        check("cfg_min", 32'(cnt_min), 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_state", 32'(state), 32'd1);
        check("run_cnt_rst_n", 32'(cnt_rst_n), 32'd1);
        // RUN cycle i (1-based): strobe when i is a multiple of 4
        for (int i = 1; i <= 12; i++) begin
            check("run_period", 32'(cnt_enable), (i % 4 == 0) ? 32'd1 : 32'd0);
            tick();
        end

        // ---- flip alignment (now prescaler 0) ----
        flip_req = 1'b1;
        check("flip_not_early", 32'(cnt_flip), 32'd0);
        tick();
        flip_req = 1'b0;      // prescaler 1
        tick();
        flip_req = 1'b1;      // prescaler 2, second request
        tick();
        flip_req = 1'b0;      // prescaler 3
        check("flip_en", 32'(cnt_enable), 32'd1);
        check("flip_once", 32'(cnt_flip), 32'd1);
        tick(); tick(); tick(); tick();   // prescaler 3 of next period
        check("flip_next_en", 32'(cnt_enable), 32'd1);
        check("flip_not_repeat", 32'(cnt_flip), 32'd0);
        tick(); tick(); tick(); tick();   // prescaler 3 again
        flip_req = 1'b1;
        #1;
        check("flip_tc_same_cycle", 32'(cnt_flip), 32'd1);
        tick();
        flip_req = 1'b0;      // prescaler 0
        tick(); tick(); tick();            // prescaler 3
        check("flip_tc_consumed", 32'(cnt_flip), 32'd0);
        tick();               // prescaler 0

        // ---- pause / resume / abort ----
        tick();               // prescaler 1
        stop = 1'b1;
        tick();
        stop = 1'b0;          // PAUSE, prescaler held at 2
        check("pause_state", 32'(state), 32'd2);
        check("pause_rst_n", 32'(cnt_rst_n), 32'd1);
        flip_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("pause_no_enable", 32'(cnt_enable), 32'd0);
            tick();
            flip_req = 1'b0;
        end
        start = 1'b1;
        tick();
        start = 1'b0;         // RUN, prescaler 2
        check("resume_state", 32'(state), 32'd1);
        check("resume_en_c1", 32'(cnt_enable), 32'd0);
        tick();               // prescaler 3
        check("resume_en_c2", 32'(cnt_enable), 32'd1);
        check("resume_pend_flip", 32'(cnt_flip), 32'd1);
        tick();
        stop = 1'b1;
        tick();
        check("stop1_state", 32'(state), 32'd2);
        tick();
        stop = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_rst_n", 32'(cnt_rst_n), 32'd0);
        start = 1'b1; stop = 1'b1;
        tick();
        check("idle_stop_wins", 32'(state), 32'd0);
        stop = 1'b0;
        tick();
        start = 1'b0;
        check("restart_state", 32'(state), 32'd1);
        stop = 1'b1;
        tick();
        check("stop_to_pause", 32'(state), 32'd2);
        start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("pause_stop_wins", 32'(state), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        // prescaler was cleared by the abort: strobe in 4th RUN cycle
        for (int i = 1; i <= 4; i++) begin
            check("after_abort_period", 32'(cnt_enable), (i == 4) ? 32'd1 : 32'd0);
            tick();
        end
        stop = 1'b1;
        tick(); tick();
        stop = 1'b0;
        check("back_idle", 32'(state), 32'd0);

        // ---- bad configuration ----
        sw_val = 4'd5; load_max = 1'b1; load_min = 1'b1;
        tick();
        load_max = 1'b0; load_min = 1'b0;
        check("both_max", 32'(cnt_max), 32'd5);
        check("both_min", 32'(cnt_min), 32'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bad_state", 32'(state), 32'd0);
        check("bad_cfg_err", 32'(cfg_err), 32'd1);
        sw_val = 4'd8; load_max = 1'b1;
        tick();
        load_max = 1'b0;
        check("load_clears_err", 32'(cfg_err), 32'd0);
        check("load_max8", 32'(cnt_max), 32'd8);
        start = 1'b1;
        tick();
        start = 1'b0;         // RUN cycle 1, prescaler 0
        check("good_start", 32'(state), 32'd1);
        sw_val = 4'd2; load_max = 1'b1;
        tick();
        load_max = 1'b0;      // RUN cycle 2, prescaler 1
        check("run_load_ignored", 32'(cnt_max), 32'd8);

        // ---- async reset mid-RUN with a pending flip ----
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;      // prescaler 2, flip pending
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_rst_n", 32'(cnt_rst_n), 32'd0);
        check("arst_enable", 32'(cnt_enable), 32'd0);
        check("arst_max", 32'(cnt_max), 32'd15);
        check("arst_min", 32'(cnt_min), 32'd0);
        #1;
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();            // RUN cycle 4
        check("arst_first_en", 32'(cnt_enable), 32'd1);
        check("arst_pend_dropped", 32'(cnt_flip), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
